// File: rtl/hazard_ctrl.sv
// Load-use / RAW hazard and memory-busy freeze controller; outputs are combinational, zero latency.
// Build with HAZARD_FWD_EN defined when a forwarding unit is present (only load-use then stalls).
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int STALL_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         id_src1_num,
    input  logic               id_src1_used,
    input  logic [3:0]         id_src2_num,
    input  logic               id_src2_used,
    input  logic [3:0]         ex_dst_num,
    input  logic               ex_wb_en,
    input  logic               ex_m2r,
    input  logic [3:0]         mem_dst_num,
    input  logic               mem_wb_en,
    input  logic               mem_busy,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               idex_flush,
    output logic               exmem_write,
    output logic               fu_enable,
    output logic               mem_err,
    output logic [STALL_W-1:0] stall_cnt,
    output logic [1:0]         state
);

`ifdef HAZARD_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FAULT    = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           tmo_q, tmo_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 m_ex, m_mem, hz;

    assign m_ex  = (id_src1_used & ex_wb_en & ({1'b0, id_src1_num} == ex_dst_num)) |
                   (id_src2_used & ex_wb_en & (id_src2_num == ex_dst_num));
    assign m_mem = (id_src1_used & mem_wb_en & ({1'b0, id_src1_num} == mem_dst_num)) |
                   (id_src2_used & mem_wb_en & (id_src2_num == mem_dst_num));

    // With forwarding only a load in EX must stall; without it any EX/MEM producer does.
    assign hz = (m_ex & (ex_m2r | ~FWD)) | (m_mem & ~FWD);

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    exmem_write = 1'b0;
                    state_d     = MEM_WAIT;
                end else begin
                    state_d = RUN;
                    if (hz) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            end
            default: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                exmem_write = 1'b0;
                state_d     = FAULT;
            end
        endcase
        if (mem_busy && (tmo_q == TMO)) begin
            state_d = FAULT;
        end
        // Reset forces the safe pattern straight away, without waiting for a clock.
        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
            exmem_write = 1'b0;
        end
    end

    always_comb begin
        tmo_d = 8'd0;
        if (mem_busy) begin
            tmo_d = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
        end
        stall_d = stall_q;
        if (!pc_write && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            tmo_q   <= 8'd0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            stall_q <= stall_d;
        end
    end

    assign fu_enable = rst & FWD;
    assign mem_err   = (state_q == FAULT);
    assign stall_cnt = stall_q;
    assign state     = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one default instance plus a MEM_TIMEOUT=3 instance for the fault path.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam int K_RUN    = 0;
    localparam int K_STALL  = 1;
    localparam int K_FREEZE = 2;
    localparam int K_RESET  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] id_src1_num;
    logic       id_src1_used;
    logic [3:0] id_src2_num;
    logic       id_src2_used;
    logic [3:0] ex_dst_num;
    logic       ex_wb_en;
    logic       ex_m2r;
    logic [3:0] mem_dst_num;
    logic       mem_wb_en;
    logic       mem_busy;

    logic        a_pcw, a_ifid, a_flush, a_exmem, a_fu, a_err;
    logic [15:0] a_scnt;
    logic [1:0]  a_st;
    logic        b_pcw, b_ifid, b_flush, b_exmem, b_fu, b_err;
    logic [15:0] b_scnt;
    logic [1:0]  b_st;

    hazard_ctrl #(.MEM_TIMEOUT(255), .STALL_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .id_src1_num(id_src1_num), .id_src1_used(id_src1_used),
        .id_src2_num(id_src2_num), .id_src2_used(id_src2_used),
        .ex_dst_num(ex_dst_num), .ex_wb_en(ex_wb_en), .ex_m2r(ex_m2r),
        .mem_dst_num(mem_dst_num), .mem_wb_en(mem_wb_en), .mem_busy(mem_busy),
        .pc_write(a_pcw), .ifid_write(a_ifid), .idex_flush(a_flush),
        .exmem_write(a_exmem), .fu_enable(a_fu), .mem_err(a_err),
        .stall_cnt(a_scnt), .state(a_st)
    );

    hazard_ctrl #(.MEM_TIMEOUT(3), .STALL_W(16)) u_dut_t3 (
        .clk(clk), .rst(rst),
        .id_src1_num(id_src1_num), .id_src1_used(id_src1_used),
        .id_src2_num(id_src2_num), .id_src2_used(id_src2_used),
        .ex_dst_num(ex_dst_num), .ex_wb_en(ex_wb_en), .ex_m2r(ex_m2r),
        .mem_dst_num(mem_dst_num), .mem_wb_en(mem_wb_en), .mem_busy(mem_busy),
        .pc_write(b_pcw), .ifid_write(b_ifid), .idex_flush(b_flush),
        .exmem_write(b_exmem), .fu_enable(b_fu), .mem_err(b_err),
        .stall_cnt(b_scnt), .state(b_st)
    );

    typedef struct packed {
        logic        pcw;
        logic        ifid;
        logic        flush;
        logic        exmem;
        logic        fu;
        logic        err;
        logic [15:0] scnt;
        logic [1:0]  st;
        logic        dut;
    } exp_t;

    exp_t        exp_q[$];
    string       tag_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] exp_scnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic clr_in();
        id_src1_num = 3'd0; id_src1_used = 1'b0;
        id_src2_num = 4'd0; id_src2_used = 1'b0;
        ex_dst_num  = 4'd0; ex_wb_en = 1'b0; ex_m2r = 1'b0;
        mem_dst_num = 4'd0; mem_wb_en = 1'b0; mem_busy = 1'b0;
    endtask

    // Push the expected outputs for the inputs now applied, then advance one cycle.
    task automatic cyc(input int kind, input logic [1:0] st, input logic dut, input string tag);
        exp_t e;
        e = '0;
        case (kind)
            K_RUN:    begin e.pcw = 1; e.ifid = 1; e.flush = 0; e.exmem = 1; end
            K_STALL:  begin e.pcw = 0; e.ifid = 0; e.flush = 1; e.exmem = 1; end
            K_FREEZE: begin e.pcw = 0; e.ifid = 0; e.flush = 0; e.exmem = 0; end
            default:  begin e.pcw = 0; e.ifid = 0; e.flush = 1; e.exmem = 0; end
        endcase
        e.fu  = (kind != K_RESET) && FWD;
        e.err = (st == 2'b10);
        e.st  = st;
        e.dut = dut;
        if (kind == K_RESET) exp_scnt = 16'd0;
        e.scnt = exp_scnt;
        if (kind != K_RESET && !e.pcw && exp_scnt != 16'hFFFF) exp_scnt = exp_scnt + 16'd1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check($sformatf("%s.pc_write", t),    e.dut ? b_pcw   : a_pcw,   e.pcw);
            check($sformatf("%s.ifid_write", t),  e.dut ? b_ifid  : a_ifid,  e.ifid);
            check($sformatf("%s.idex_flush", t),  e.dut ? b_flush : a_flush, e.flush);
            check($sformatf("%s.exmem_write", t), e.dut ? b_exmem : a_exmem, e.exmem);
            check($sformatf("%s.fu_enable", t),   e.dut ? b_fu    : a_fu,    e.fu);
            check($sformatf("%s.mem_err", t),     e.dut ? b_err   : a_err,   e.err);
            check($sformatf("%s.stall_cnt", t),   e.dut ? b_scnt  : a_scnt,  e.scnt);
            check($sformatf("%s.state", t),       e.dut ? b_st    : a_st,    e.st);
        end
    end

    initial begin
        exp_scnt = 16'd0;
        rst = 1'b0;
        clr_in();
        @(posedge clk);
        #1;
        cyc(K_RESET, 2'b00, 0, "reset0");
        cyc(K_RESET, 2'b00, 0, "reset1");

        // Release with no sources read, even though producers target R0.
        rst = 1'b1;
        cyc(K_RUN, 2'b00, 0, "rel_idle");
        ex_wb_en = 1; mem_wb_en = 1;
        cyc(K_RUN, 2'b00, 0, "rel_unused");

        // Load-use on R3 followed by the load moving to MEM.
        clr_in();
        ex_dst_num = 4'd3; ex_wb_en = 1; ex_m2r = 1; id_src1_num = 3'd3; id_src1_used = 1;
        cyc(K_STALL, 2'b00, 0, "lu_ex");
        ex_wb_en = 0; ex_m2r = 0; mem_dst_num = 4'd3; mem_wb_en = 1;
        cyc(FWD ? K_RUN : K_STALL, 2'b00, 0, "lu_mem");
        mem_wb_en = 0;
        cyc(K_RUN, 2'b00, 0, "lu_done");

        // Source 1 is zero-extended: R3 must not match R11.
        clr_in();
        ex_dst_num = 4'd11; ex_wb_en = 1; ex_m2r = 1; id_src1_num = 3'd3; id_src1_used = 1;
        mem_dst_num = 4'd11; mem_wb_en = 1;
        cyc(K_RUN, 2'b00, 0, "zext");

        // ALU producer of R5 against source 2.
        clr_in();
        ex_dst_num = 4'd5; ex_wb_en = 1; id_src2_num = 4'd5;
        cyc(K_RUN, 2'b00, 0, "alu_unused");
        id_src2_used = 1;
        cyc(FWD ? K_RUN : K_STALL, 2'b00, 0, "alu_ex");
        ex_wb_en = 0; mem_dst_num = 4'd5; mem_wb_en = 1;
        cyc(FWD ? K_RUN : K_STALL, 2'b00, 0, "alu_mem");
        mem_wb_en = 0;
        cyc(K_RUN, 2'b00, 0, "alu_done");

        // Memory busy for four edges while a load-use match is pending.
        clr_in();
        ex_dst_num = 4'd3; ex_wb_en = 1; ex_m2r = 1; id_src1_num = 3'd3; id_src1_used = 1;
        mem_busy = 1;
        cyc(K_FREEZE, 2'b00, 0, "busy1");
        cyc(K_FREEZE, 2'b01, 0, "busy2");
        cyc(K_FREEZE, 2'b01, 0, "busy3");
        cyc(K_FREEZE, 2'b01, 0, "busy4");
        mem_busy = 0;
        cyc(K_STALL, 2'b01, 0, "busy_lu");
        ex_wb_en = 0; ex_m2r = 0; mem_dst_num = 4'd3; mem_wb_en = 1;
        cyc(FWD ? K_RUN : K_STALL, 2'b00, 0, "busy_mem");
        clr_in();
        cyc(K_RUN, 2'b00, 0, "busy_done");

        // Reset asserted mid-freeze takes effect without a clock edge.
        mem_busy = 1;
        cyc(K_FREEZE, 2'b00, 0, "mw_a");
        cyc(K_FREEZE, 2'b01, 0, "mw_b");
        rst = 1'b0;
        cyc(K_RESET, 2'b00, 0, "mw_rst");
        rst = 1'b1; mem_busy = 0;
        cyc(K_RUN, 2'b00, 0, "mw_rel");

        // Timeout on the MEM_TIMEOUT=3 instance.
        rst = 1'b0;
        cyc(K_RESET, 2'b00, 1, "to_rst");
        rst = 1'b1; mem_busy = 1;
        cyc(K_FREEZE, 2'b00, 1, "to_e0");
        cyc(K_FREEZE, 2'b01, 1, "to_e1");
        cyc(K_FREEZE, 2'b01, 1, "to_e2");
        cyc(K_FREEZE, 2'b01, 1, "to_e3");
        cyc(K_FREEZE, 2'b10, 1, "to_fault");
        mem_busy = 0;
        cyc(K_FREEZE, 2'b10, 1, "to_hold1");
        cyc(K_FREEZE, 2'b10, 1, "to_hold2");
        rst = 1'b0;
        cyc(K_RESET, 2'b00, 1, "to_clr");
        rst = 1'b1;
        cyc(K_RUN, 2'b00, 1, "to_rel");
        cyc(K_RUN, 2'b00, 0, "final");

        repeat (3) @(negedge clk);
        check("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage processor. It detects read-after-write hazards between the instruction in decode and the older instructions in EX and MEM. It drives the PC and IF/ID write enables, the ID/EX flush, and the EX/MEM hold. It gates the forwarding unit through `fu_enable` and freezes the pipeline while data memory reports busy. It sits beside the forwarding unit and takes its register numbers from the ID, EX and MEM pipeline registers.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: consecutive `mem_busy` cycles tolerated before a fault is declared (1..255).
- `STALL_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_src1_num` in 3: decode source 1 register number.
- `id_src1_used` in 1: source 1 is read by the decode instruction.
- `id_src2_num` in 4: decode source 2 register number.
- `id_src2_used` in 1: source 2 is read.
- `ex_dst_num` in 4: destination of the instruction in EX.
- `ex_wb_en` in 1: EX instruction writes a register.
- `ex_m2r` in 1: EX instruction is a load (memory-to-register).
- `mem_dst_num` in 4: destination of the instruction in MEM.
- `mem_wb_en` in 1: MEM instruction writes a register.
- `mem_busy` in 1: data memory has not completed the access in MEM.
- `pc_write` out 1: PC update enable.
- `ifid_write` out 1: IF/ID register write enable.
- `idex_flush` out 1: load a bubble into ID/EX.
- `exmem_write` out 1: EX/MEM and MEM/WB write enable.
- `fu_enable` out 1: forwarding unit enable.
- `mem_err` out 1: sticky memory-timeout fault.
- `stall_cnt` out STALL_W: saturating count of stalled cycles.
- `state` out 2: FSM state (RUN=00, MEM_WAIT=01, FAULT=10).

## Operation
- Match rules:
  - `m_ex` = (`id_src1_used` and `ex_wb_en` and {0,`id_src1_num`}==`ex_dst_num`) or (`id_src2_used` and `ex_wb_en` and `id_src2_num`==`ex_dst_num`).
  - `m_mem` uses the same rule with the `mem_*` signals.
  - Source 1 is zero-extended to 4 bits before the compare.
- Hazard: `hz` = `m_ex` and `ex_m2r` (load-use).
- Outputs are combinational from the state and current inputs.
- RUN:
  - If `mem_busy`=1: freeze. `pc_write`=0, `ifid_write`=0, `idex_flush`=0, `exmem_write`=0. Next state is MEM_WAIT.
  - Else if `hz`: stall. `pc_write`=0, `ifid_write`=0, `idex_flush`=1, `exmem_write`=1.
  - Else: all write enables are 1 and `idex_flush`=0.
- MEM_WAIT:
  - Freeze outputs as above while `mem_busy`=1.
  - When `mem_busy`=0, outputs revert to RUN evaluation in the same cycle, and the next state is RUN.
- FAULT: freeze outputs permanently and hold `mem_err`=1. Only reset exits FAULT.
- Timeout counter:
  - Increments on each edge with `mem_busy`=1 and clears otherwise.
  - If the counter equals `MEM_TIMEOUT` and `mem_busy`=1 at an edge, the next state is FAULT.
- `mem_busy` has priority over the hazard stall. There is no flush during a freeze, so the decode instruction is re-evaluated afterwards.
- `stall_cnt` increments on every edge with `pc_write`=0 and saturates at all-ones.
- `fu_enable`=1 whenever `rst`=1.

## Timing
- Reset values (forced while `rst`=0):
  - `pc_write`=0, `ifid_write`=0, `idex_flush`=1, `exmem_write`=0, `fu_enable`=0.
  - `mem_err`=0, `stall_cnt`=0, `state`=RUN, timeout counter=0.
- Stall and freeze signals respond combinationally in the same cycle the condition is present. There is zero latency.
- A load-use hazard costs exactly one cycle. The next cycle, EX holds the bubble, so `hz`=0 and forwarding from MEM supplies the value.
- Reset asserted mid-freeze or in FAULT returns to RUN immediately; no waiting for a clock edge.
- When `mem_busy` falls, the counter clears on the next edge.

## Configuration
- `HAZARD_FWD_EN` defined: the behaviour is as above, `fu_enable`=1 out of reset, and only load-use produces a stall.
- `HAZARD_FWD_EN` undefined:
  - `fu_enable` is tied to 0.
  - `hz` = `m_ex` or `m_mem`, regardless of `ex_m2r`.
  - A dependence on EX stalls 2 cycles; a dependence on MEM stalls 1 cycle. The register file writes in the first half-cycle and reads in the second.

## Test plan
- Reset release with no matches (all `*_used`=0) -> `pc_write`=1, `ifid_write`=1, `idex_flush`=0, `fu_enable`=1, `state`=00.
- Load to R3 in EX (`ex_m2r`=1, `ex_wb_en`=1, `ex_dst_num`=3), decode `id_src1_num`=3, used -> one cycle with `pc_write`=0, `idex_flush`=1; next cycle no stall; `stall_cnt`=1.
- ALU write to R5 in EX, decode `id_src2_num`=5 -> no stall with the macro defined; 2 stall cycles with the macro undefined.
- `mem_busy` high 4 cycles during a load-use match -> 4 freeze cycles with `idex_flush`=0 and `state`=01, then 1 hazard stall; `stall_cnt`=5.
- `MEM_TIMEOUT`=3, `mem_busy` held high -> `state`=10 and `mem_err`=1 after the 4th busy edge. `mem_busy` then dropped -> the pipeline stays frozen until `rst`=0.
- `rst` pulsed low during MEM_WAIT -> reset values appear immediately; after release, `state`=00 and the counters are 0.
